// File: rtl/seq_detect_1011_if.sv
// Bit-stream handshake bundle for the 1011 detector.
// master drives en/din/clr; slave returns detected/count/state.
interface seq_detect_1011_if #(
  parameter int COUNT_W = 4
);
  logic               en;
  logic               din;
  logic               clr;
  logic               detected;
  logic [COUNT_W-1:0] count;
  logic [2:0]         state;

  modport master (
    output en,
    output din,
    output clr,
    input  detected,
    input  count,
    input  state
  );

  modport slave (
    input  en,
    input  din,
    input  clr,
    output detected,
    output count,
    output state
  );
endinterface

// File: rtl/seq_detect_1011.sv
// Moore detector for serial 1-0-1-1 (overlapping), saturating count.
// Ports: clk, rst (sync, active-high), bus (slave: en/din/clr in; detected/count/state out).
module seq_detect_1011 #(
  parameter int COUNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  seq_detect_1011_if.slave bus
);

  typedef enum logic [2:0] {
    S0    = 3'd0,
    S1    = 3'd1,
    S10   = 3'd2,
    S101  = 3'd3,
    S1011 = 3'd4
  } state_t;

  localparam logic [COUNT_W-1:0] CMAX = '1;
  localparam logic [COUNT_W-1:0] ONE  = 1;

  state_t             st;
  state_t             nx;
  logic [COUNT_W-1:0] cnt;
  logic               det;
  logic               bad;
  logic               hit;

  // Codes 5-7 recover to S0 even with en low.
  assign bad = (st > S1011);
  assign hit = bus.en && (st == S101) && bus.din;

  always_comb begin
    nx = S0;
    unique case (st)
      S0:      nx = bus.din ? S1    : S0;
      S1:      nx = bus.din ? S1    : S10;
      S10:     nx = bus.din ? S101  : S0;
      S101:    nx = bus.din ? S1011 : S10;
      S1011:   nx = bus.din ? S1    : S10;
      default: nx = S0;
    endcase
  end

  // detected is registered from the next state, so it
  // always equals (state == S1011) with no path from din.
  always_ff @(posedge clk) begin
    if (rst) begin
      st  <= S0;
      cnt <= '0;
      det <= 1'b0;
    end else begin
      if (bad) begin
        st  <= S0;
        det <= 1'b0;
      end else if (bus.en) begin
        st  <= nx;
        det <= (nx == S1011);
      end
      if (bus.clr)
        cnt <= '0;
      else if (hit && cnt != CMAX)
        cnt <= cnt + ONE;
    end
  end

  assign bus.detected = det;
  assign bus.count    = cnt;
  assign bus.state    = st;

endmodule
